// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: word type, NOP word,
// read-pipeline state encoding and byte-address to word-index conversion.
package imem_arbiter_pkg;

  localparam int IDX_W_DEF = 8;

  typedef logic [31:0] word_t;

  localparam word_t NOP_WORD = 32'h0;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_PEND = 1'b1;

  // Callers keep the low IDX_W bits; higher bits alias modulo the memory depth.
  function automatic word_t word_idx(input word_t byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch and loader handshake bundle; master = requesters, slave = arbiter.
interface imem_arbiter_if;
  import imem_arbiter_pkg::*;

  logic  if_req;
  word_t if_addr;
  logic  if_flush;
  logic  if_gnt;
  logic  if_rvalid;
  word_t if_rdata;
  logic  ld_req;
  word_t ld_addr;
  word_t ld_wdata;
  logic  ld_gnt;

  modport master (
    output if_req, if_addr, if_flush, ld_req, ld_addr, ld_wdata,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt
  );

  modport slave (
    input  if_req, if_addr, if_flush, ld_req, ld_addr, ld_wdata,
    output if_gnt, if_rvalid, if_rdata, ld_gnt
  );

endinterface

// File: rtl/imem_starve_ctr.sv
// Counts consecutive cycles in which a waiting fetch lost to the loader and
// raises force_fetch once the limit is reached.
module imem_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  input  logic ld_gnt,
  output logic force_fetch
);

  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (ld_gnt && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign force_fetch = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader writes vs. IF fetch reads,
// with one-cycle read return, flush squashing and a saturating load counter.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  imem_arbiter_if.slave    bus,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output word_t            mem_wdata,
  input  word_t            mem_rdata,
  output logic [IDX_W:0]   ld_count
);

  localparam logic [IDX_W:0] LD_MAX = {1'b1, {IDX_W{1'b0}}};

  word_t      if_word;
  word_t      ld_word;
  logic       force_fetch;
  logic       fetch_win;
  logic       load_win;
  logic [0:0] rd_pend;
  logic       unused_idx_bits;

  assign if_word = word_idx(bus.if_addr);
  assign ld_word = word_idx(bus.ld_addr);
  assign unused_idx_bits = ^{if_word[31:IDX_W], ld_word[31:IDX_W]};

  imem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk        (clk),
    .reset      (reset),
    .if_req     (bus.if_req),
    .if_gnt     (fetch_win),
    .ld_gnt     (load_win),
    .force_fetch(force_fetch)
  );

  // Stage 0: grant decision; the loader wins ties unless fetch has waited too long.
  always_comb begin
    fetch_win = 1'b0;
    load_win  = 1'b0;
    if (!reset) begin
      if (bus.if_req && (!bus.ld_req || force_fetch)) begin
        fetch_win = 1'b1;
      end else if (bus.ld_req) begin
        load_win = 1'b1;
      end
    end
  end

  assign bus.if_gnt = fetch_win;
  assign bus.ld_gnt = load_win;
  assign mem_en     = fetch_win | load_win;
  assign mem_we     = load_win;
  assign mem_idx    = load_win  ? ld_word[IDX_W-1:0] :
                      fetch_win ? if_word[IDX_W-1:0] : '0;
  assign mem_wdata  = load_win ? bus.ld_wdata : NOP_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= RD_IDLE;
      ld_count <= '0;
    end else begin
      rd_pend <= (fetch_win && !bus.if_flush) ? RD_PEND : RD_IDLE;
      if (load_win && (ld_count != LD_MAX)) begin
        ld_count <= ld_count + 1'b1;
      end
    end
  end

  // Stage 1: registered RAM data returns; a flush arriving now discards it.
  assign bus.if_rvalid = (rd_pend == RD_PEND) && !bus.if_flush && !reset;
  assign bus.if_rdata  = bus.if_rvalid ? mem_rdata : NOP_WORD;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port arbiter and sequencer for the instruction memory, shared between the IF-stage fetch path and the program loader (UART/debug bootloader). Each cycle it grants at most one access: a loader write or a fetch read. It drives the memory port, tracks the one-cycle read latency, and returns fetched words to IF. It sits between the IF stage, the loader and a synchronous single-port instruction RAM with registered read data.

## Interface
Parameters:
- IDX_W, 8, word-index width; memory depth 2^IDX_W words; index = byte address[IDX_W+1:2]
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_flush  in  1  cancel the in-flight fetch (branch/jump redirect)
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetched word valid this cycle
- if_rdata  out  32  fetched instruction; 32'h0 (NOP) when if_rvalid=0
- ld_req  in  1  loader write request
- ld_addr  in  32  loader byte address; bits [1:0] ignored
- ld_wdata  in  32  word to write
- ld_gnt  out  1  write granted and performed this cycle (combinational)
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_idx  out  IDX_W  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a read
- ld_count  out  IDX_W+1  words written since reset, saturating

## Operation
- Arbitration, evaluated combinationally each cycle:
  - Both requests present: the loader wins, unless starve_cnt == MAX_WAIT, in which case fetch wins.
  - Single requester: that requester is granted.
  - No requester: mem_en=0.
  - Never grant both in one cycle.
- Fetch grant drives: mem_en=1, mem_we=0, mem_idx=if_addr[IDX_W+1:2].
- Loader grant drives: mem_en=1, mem_we=1, mem_idx=ld_addr[IDX_W+1:2], mem_wdata=ld_wdata.
- mem_wdata=0 when no write is granted.
- starve_cnt (width clog2(MAX_WAIT+1)):
  - Increments when if_req=1 and ld_gnt=1.
  - Clears on if_gnt or when if_req=0.
  - Never exceeds MAX_WAIT.
- Read pipeline: state RD_IDLE / RD_PEND (rd_pend flop).
  - rd_pend_next = if_gnt & ~if_flush.
  - if_rvalid = rd_pend & ~if_flush.
  - if_rdata = if_rvalid ? mem_rdata : 32'h0.
  - Back-to-back fetch grants are allowed: RD_PEND→RD_PEND every cycle.
- if_flush squashes the word returning this cycle and the fetch granted this cycle. The memory access still happens; its data is discarded.
- ld_count increments on each ld_gnt and saturates at 2^IDX_W.
- Address wrap: an index beyond depth aliases modulo 2^IDX_W. There is no error flag.

## Timing
- Grant latency: 0 cycles (combinational from requests and starve_cnt).
- Read latency: word on if_rdata 1 cycle after the if_gnt cycle.
- Write latency: the memory captures the write at the clk edge ending the ld_gnt cycle. A fetch of the same index in the following cycle returns the new word.
- Requesters hold req/addr/data stable until granted. The arbiter does not buffer.
- Reset (synchronous): rd_pend=0, starve_cnt=0, ld_count=0.
  - During a reset cycle: if_gnt=0, ld_gnt=0, mem_en=0, mem_we=0, if_rvalid=0, if_rdata=0.
  - Reset mid-read discards the pending word. Reset mid-load loses ungranted words only.
- Flush and reset in the same cycle: reset dominates; the result is identical to reset alone.

## Structure
- A shared package holds: IDX_W default, the NOP word 32'h0, the rd state encoding (RD_IDLE=0, RD_PEND=1) and the word-index extraction function (byte address → index).
- One sub-module: imem_starve_ctr (saturating starvation counter with a force output). The rest is flat.
- The memory itself lives outside this block.

## Test plan
- Fetch only: if_req=1 with if_addr=0,4,8 on consecutive cycles, mem_rdata returns 0x2004000?/loaded values → if_gnt=1 every cycle; if_rvalid=1 from cycle 2 onward; if_rdata equals mem_rdata one cycle after each index 0,1,2.
- Load then fetch: ld_req writes 0x20040007 at address 0x0; next cycle fetch address 0x0 → ld_gnt=1 and ld_count=1; the following cycle if_rdata=0x20040007.
- Starvation, MAX_WAIT=4: ld_req and if_req held high for 10 cycles → ld_gnt for 4 cycles, if_gnt in cycle 5, then the pattern repeats; ld_gnt and if_gnt are never high together.
- Flush: fetch granted at cycle N with if_flush=1 at N+1 → if_rvalid=0 and if_rdata=0 at N+1.
- Wrap and saturation, IDX_W=8: a loader write at byte address 0x400 → mem_idx=0. 257 writes → ld_count stops at 256.
- Reset mid-read: if_gnt at cycle N, reset at N+1 → if_rvalid=0 at N+1; all outputs at reset values; normal operation resumes at N+2.
